// File: rtl/cam_init_seq.sv
// cam_init_seq: ROM-table driven camera register init sequencer (writes, delays, skips, end marker).
// Define CAM_INIT_VERIFY_EN to add read-back verification after every accepted write.
module cam_init_seq #(
    parameter int IDX_W      = 8,
    parameter int REG_W      = 8,
    parameter int VAL_W      = 8,
    parameter int DELAY_UNIT = 250000,
    parameter int AUTO_START = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [IDX_W-1:0]       rom_addr,
    input  logic [REG_W+VAL_W-1:0] rom_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [REG_W-1:0]       wr_reg,
    output logic [VAL_W-1:0]       wr_val,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    input  logic [VAL_W-1:0]       rd_data,
    input  logic                   rd_data_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [7:0]             mismatch_cnt
);
    localparam int CNT_W = $clog2(15 * DELAY_UNIT);

`ifdef CAM_INIT_VERIFY_EN
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, DELAY, VERIFY_REQ, VERIFY_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, DELAY} state_t;
`endif

    state_t           state, state_n;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             armed, go, adv;
    logic [VAL_W-1:0] dval;
    logic             reg_ones, is_end, is_dly, is_wr;

    assign dval     = rom_data[VAL_W-1:0];
    assign reg_ones = &rom_data[REG_W+VAL_W-1:VAL_W];
    assign is_end   = reg_ones & (&dval);
    assign is_dly   = reg_ones & (&dval[VAL_W-1:4]) & ~(&dval);
    assign is_wr    = ~reg_ones;
    assign go       = start | armed;
    assign rom_addr = idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        adv     = 1'b0;
        case (state)
            IDLE:   state_n = go ? FETCH : IDLE;
            FETCH:  state_n = DECODE;
            DECODE: begin
                if (is_end)      state_n = IDLE;
                else if (is_dly) state_n = DELAY;
                else if (is_wr)  state_n = WRITE;
                else             adv = 1'b1;
            end
`ifdef CAM_INIT_VERIFY_EN
            WRITE:       state_n = wr_ready ? VERIFY_REQ : WRITE;
            VERIFY_REQ:  state_n = rd_ready ? VERIFY_WAIT : VERIFY_REQ;
            VERIFY_WAIT: adv = rd_data_valid;
`else
            WRITE:  adv = wr_ready;
`endif
            DELAY:  adv = (cnt == '0);
            default: state_n = IDLE;
        endcase
        if (adv) state_n = (&idx) ? IDLE : FETCH;
    end

    always_comb begin
        wr_valid = (state == WRITE);
        busy     = (state != IDLE);
`ifdef CAM_INIT_VERIFY_EN
        rd_valid = (state == VERIFY_REQ);
`else
        rd_valid = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            cnt     <= '0;
            wr_reg  <= '0;
            wr_val  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            armed   <= (AUTO_START != 0);
        end else begin
            armed <= 1'b0;
            if (state == IDLE && go) begin
                idx     <= '0;
                done    <= 1'b0;
                overrun <= 1'b0;
            end
            if (state == DECODE && is_end) done <= 1'b1;
            // counter runs (n+1)*DELAY_UNIT cycles including the zero cycle
            if (state == DECODE && is_dly) cnt <= CNT_W'((int'(dval[3:0]) + 1) * DELAY_UNIT - 1);
            else if (state == DELAY)       cnt <= cnt - 1'b1;
            if (state == DECODE && is_wr) {wr_reg, wr_val} <= rom_data;
            if (adv) begin
                if (&idx) overrun <= 1'b1;
                else      idx <= idx + 1'b1;
            end
        end
    end

`ifdef CAM_INIT_VERIFY_EN
    logic [7:0] mis;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                mis <= '0;
        else if (state == IDLE && go) mis <= '0;
        else if (state == VERIFY_WAIT && rd_data_valid && rd_data != wr_val && mis != 8'hFF)
            mis <= mis + 1'b1;
    end
    assign mismatch_cnt = mis;
`else
    logic unused_rd;
    assign unused_rd    = ^{rd_ready, rd_data, rd_data_valid};
    assign mismatch_cnt = '0;
`endif
endmodule

// File: doc/cam_init_seq.md
# cam_init_seq

Parametrised camera register-initialisation sequencer. It walks a register table held in an external synchronous ROM. For each table entry it does one of four things: issues a register write over a valid/ready handshake to the SCCB master, inserts a programmable delay, skips a reserved entry, or stops at the end marker. It sits between the camera config ROM and the SCCB master, replacing free-running ROM indexing with a restartable, delay-aware, optionally read-back-verified sequence.

## Interface
Parameters:
- IDX_W, 8, table index width; table depth is 2^IDX_W entries.
- REG_W, 8, register-address field width.
- VAL_W, 8, register-value field width; must be at least 4.
- DELAY_UNIT, 250000, clock cycles per delay unit (10 ms at 25 MHz).
- AUTO_START, 1, when 1 a sequence starts automatically on the first cycle after reset release.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts the sequence from index 0. Ignored while busy.
- rom_addr  out  IDX_W  table index. Reset value 0.
- rom_data  in  REG_W+VAL_W  entry {reg,val}; valid one cycle after rom_addr.
- wr_valid  out  1  write request. Reset value 0.
- wr_ready  in  1  SCCB master accepts the write.
- wr_reg  out  REG_W  register address. Reset value 0.
- wr_val  out  VAL_W  register value. Reset value 0.
- rd_valid  out  1  read-back request (verify build only). Reset value 0.
- rd_ready  in  1  read request accepted.
- rd_data  in  VAL_W  read-back data.
- rd_data_valid  in  1  rd_data is valid this cycle.
- busy  out  1  sequence in progress. Reset value 0.
- done  out  1  sticky; set when the end marker is reached, cleared by start. Reset value 0.
- overrun  out  1  sticky; set when the last index is processed and it was not the end marker. Reset value 0.
- mismatch_cnt  out  8  saturating count of verify mismatches. Reset value 0.

## Operation
- States: IDLE, FETCH, DECODE, WRITE, DELAY, VERIFY_REQ, VERIFY_WAIT.
- IDLE
  - start (or the first cycle after reset when AUTO_START=1) sets idx=0 and clears done, overrun and mismatch_cnt.
  - Next state is FETCH.
- FETCH
  - rom_addr=idx.
  - Next state is DECODE.
- DECODE classifies rom_data:
  - reg all ones and val all ones: end marker. Set done and go to IDLE.
  - reg all ones and val[VAL_W-1:4] all ones (low nibble n in 0..14): delay entry. Load a counter with (n+1)*DELAY_UNIT-1 and go to DELAY.
  - reg all ones, any other val: reserved entry. Skip it.
  - anything else: latch wr_reg and wr_val and go to WRITE.
- WRITE
  - wr_valid is held high; wr_reg and wr_val are stable until wr_valid && wr_ready.
  - On the handshake: go to VERIFY_REQ in the verify build, otherwise advance.
- DELAY
  - The counter decrements once per cycle.
  - Advance after the cycle in which the counter is 0.
- Advance rule:
  - If idx is the maximum (2^IDX_W-1), set overrun and go to IDLE.
  - Otherwise increment idx and go to FETCH.
- busy is high in every state except IDLE.
- The delay counter width is $clog2(15*DELAY_UNIT).
- reset_n low asserts all reset values immediately, from any state, including mid-handshake and mid-delay. No partial write is retried.

## Timing
- start is sampled at edge k.
  - FETCH during cycle k+1, with rom_addr=0.
  - DECODE during cycle k+2.
  - wr_valid is high from cycle k+3.
- Write entry throughput is 3 cycles plus wr_ready wait.
- A skipped entry costs 2 cycles: FETCH and DECODE.
- A delay entry with nibble n holds DELAY for exactly (n+1)*DELAY_UNIT cycles.
- wr_valid deasserts in the cycle after the handshake. It never drops before the handshake.
- start arriving in the same cycle that DECODE hits the end marker is ignored. busy is still high in that cycle.

## Configuration
- CAM_INIT_VERIFY_EN defined:
  - After each accepted write, go to VERIFY_REQ. rd_valid is high with the address on wr_reg until rd_valid && rd_ready.
  - Then wait in VERIFY_WAIT for rd_data_valid.
  - If rd_data != wr_val, increment mismatch_cnt, saturating at 255.
  - Then advance. The sequence never stalls on a mismatch.
- CAM_INIT_VERIFY_EN undefined:
  - VERIFY states are absent.
  - rd_valid is held at 0 and mismatch_cnt is held at 0.
  - rd_ready, rd_data and rd_data_valid are ignored.

## Test plan
- Table {0x1280, 0xFFF0, 0x1214, 0xFFFF}, DELAY_UNIT=4, wr_ready tied high:
  - exactly two writes occur, 0x12/0x80 and then 0x12/0x14;
  - they are separated by exactly 4 DELAY cycles;
  - done=1 and busy=0 at the end.
- wr_ready held low for 10 cycles on the first write:
  - wr_valid, wr_reg and wr_val are stable for all 10 cycles;
  - exactly one write completes.
- Delay entry 0xFFF3 with DELAY_UNIT=4: DELAY lasts 16 cycles. Entry 0xFF12 produces no write and costs 2 cycles.
- IDX_W=2 with a table containing no end marker:
  - four entries are processed;
  - overrun=1, done=0, busy=0.
- reset_n pulsed low during a delay and during a wr_valid stall:
  - all outputs return to their reset values immediately;
  - with AUTO_START=1, the sequence restarts at index 0.
- Verify build, with read-back returning 0x00 for the 0x1214 write: mismatch_cnt=1, and the sequence still reaches done.
